// File: rtl/lsu_bus_adapter_if.sv
// lsu_bus_adapter_if: word-aligned valid/ready bus between the load/store adapter and memory.
interface lsu_bus_adapter_if;
    logic [31:0] BusAdr;
    logic [31:0] BusWData;
    logic [3:0]  BusWStrb;
    logic        BusWrite;
    logic        BusValid;
    logic        BusReady;
    logic        BusRValid;
    logic [31:0] BusRData;
    modport master (
        output BusAdr, BusWData, BusWStrb, BusWrite, BusValid,
        input  BusReady, BusRValid, BusRData
    );
    modport slave (
        input  BusAdr, BusWData, BusWStrb, BusWrite, BusValid,
        output BusReady, BusRValid, BusRData
    );
endinterface

// File: rtl/lsu_bus_adapter.sv
// lsu_bus_adapter: turns single-cycle core loads/stores into stalled word-aligned bus transactions.
module lsu_bus_adapter #(
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        Funct3,
    input  logic [31:0]       IEUAdr,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              Stall,
    output logic              Misaligned,
    output logic              BusErr,
    lsu_bus_adapter_if.master bus
);
    localparam int CW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;
    state_e        state_q, state_d;
    logic [31:0]   rdata_q, rdata_d, adr_q, adr_d, wdata_q, wdata_d;
    logic [3:0]    strb_q, strb_d;
    logic          write_q, write_d, err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req, is_b, is_h, is_w, issue, tmo, fin;
    assign req        = MemRead | MemWrite;
    assign is_b       = Funct3 inside {3'b000, 3'b100};
    assign is_h       = Funct3 inside {3'b001, 3'b101};
    assign is_w       = !is_b && !is_h;
    assign Misaligned = req && state_q == IDLE && ((is_h && IEUAdr[0]) || (is_w && |IEUAdr[1:0]));
    assign Stall      = req && !Misaligned && state_q != DONE;
    assign issue      = req && !Misaligned && state_q == IDLE;
    assign tmo        = cnt_q == CW'(TIMEOUT - 1);
    // a response in the same cycle as the accept completes the access directly from REQ
    assign fin        = state_q == REQ ? bus.BusReady && bus.BusRValid : bus.BusRValid;
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        write_d = write_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (issue) begin
                state_d = REQ;
                cnt_d   = '0;
                adr_d   = {IEUAdr[31:2], 2'b00};
                write_d = MemWrite;
                wdata_d = !MemWrite ? 32'h0 : is_b ? {4{WriteData[7:0]}} :
                          is_h ? {2{WriteData[15:0]}} : WriteData;
                strb_d  = !MemWrite ? 4'b0000 : is_b ? 4'b0001 << IEUAdr[1:0] :
                          is_h ? (IEUAdr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
            end
            REQ, RESP: begin
                cnt_d = cnt_q + 1'b1;
                if (fin) begin
                    state_d = DONE;
                    rdata_d = write_q ? rdata_q : bus.BusRData;
                end else if (tmo) begin
                    state_d = DONE;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else if (state_q == REQ && bus.BusReady) begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rdata_q <= '0;
            adr_q   <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            write_q <= write_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
    assign ReadData     = rdata_q;
    assign BusErr       = err_q;
    assign bus.BusAdr   = adr_q;
    assign bus.BusWData = wdata_q;
    assign bus.BusWStrb = strb_q;
    assign bus.BusWrite = write_q;
    assign bus.BusValid = state_q == REQ;
endmodule

// File: tb/tb_lsu_bus_adapter.sv
// tb_lsu_bus_adapter: vector table, directed corner sequences and random accesses against a byte-lane model.
module tb_lsu_bus_adapter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    logic        MemRead, MemWrite, Stall, Misaligned, BusErr;
    logic [2:0]  Funct3;
    logic [31:0] IEUAdr, WriteData, ReadData;
    lsu_bus_adapter_if bus();
    lsu_bus_adapter #(.TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
        .IEUAdr(IEUAdr), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
        .Misaligned(Misaligned), .BusErr(BusErr), .bus(bus.master)
    );
    logic        t_rd, t_wr, t_stall, t_mis, t_err;
    logic [2:0]  t_f3;
    logic [31:0] t_adr, t_wd, t_rdata;
    lsu_bus_adapter_if bus8();
    lsu_bus_adapter #(.TIMEOUT(8)) dut8 (
        .clk(clk), .reset(reset), .MemRead(t_rd), .MemWrite(t_wr), .Funct3(t_f3),
        .IEUAdr(t_adr), .WriteData(t_wd), .ReadData(t_rdata), .Stall(t_stall),
        .Misaligned(t_mis), .BusErr(t_err), .bus(bus8.master)
    );
    int n_chk = 0, n_fail = 0, hs_cnt = 0;
    logic [31:0] model_rd = '0;
    bit at_done = 1'b0;
    always @(posedge clk) if (bus.BusValid && bus.BusReady) hs_cnt <= hs_cnt + 1;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    // byte-lane view: lane i is written when it lies inside [offset, offset+size), fed by data byte i%size
    function automatic void model(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                                  output logic [31:0] e_wd, output logic [3:0] e_strb,
                                  output logic e_mis, output logic [31:0] e_rd);
        int sz, off;
        sz = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        off = int'(a % 4);
        e_mis = (off % sz) != 0;
        e_wd = '0;
        e_strb = '0;
        if (wr && !e_mis)
            for (int i = 0; i < 4; i++) begin
                e_strb[i] = i >= off && i < off + sz;
                e_wd[8*i +: 8] = wd[8*(i % sz) +: 8];
            end
        e_rd = (rd && !e_mis) ? rdat : model_rd;
    endfunction
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rdat, input logic [31:0] e_wd,
                          input logic [3:0] e_strb, input logic e_mis, input logic [31:0] e_rd,
                          input int rdly, input int vdly, input bit hold);
        int hs0;
        MemRead = rd; MemWrite = wr; Funct3 = f3; IEUAdr = a; WriteData = wd;
        bus.BusReady = 1'b0; bus.BusRValid = 1'b0; bus.BusRData = ~rdat;
        if (at_done) @(negedge clk); else #1;
        hs0 = hs_cnt;
        chk("misaligned", Misaligned, e_mis);
        chk("stall_idle", Stall, !e_mis);
        if (e_mis) begin
            @(negedge clk);
            chk("mis_valid", bus.BusValid, 0);
            chk("mis_rdata", ReadData, e_rd);
            MemRead = 0; MemWrite = 0;
            @(negedge clk);
            chk("mis_hs", hs_cnt - hs0, 0);
            at_done = 1'b0;
            return;
        end
        for (int i = 0; i <= rdly; i++) begin
            @(negedge clk);
            chk("req_valid", bus.BusValid, 1);
            chk("req_adr", bus.BusAdr, {a[31:2], 2'b00});
            chk("req_wdata", bus.BusWData, e_wd);
            chk("req_strb", bus.BusWStrb, e_strb);
            chk("req_write", bus.BusWrite, wr);
            chk("req_stall", Stall, 1);
            if (i == rdly) begin
                bus.BusReady = 1'b1;
                bus.BusRValid = vdly == 0;
                bus.BusRData = vdly == 0 ? rdat : ~rdat;
            end
        end
        for (int j = 1; j <= vdly; j++) begin
            @(negedge clk);
            bus.BusReady = 1'b0; bus.BusRValid = 1'b0;
            chk("resp_valid", bus.BusValid, 0);
            chk("resp_stall", Stall, 1);
            if (j == vdly) begin
                bus.BusRValid = 1'b1;
                bus.BusRData = rdat;
            end
        end
        @(negedge clk);
        bus.BusReady = 1'b0; bus.BusRValid = 1'b0;
        chk("done_stall", Stall, 0);
        chk("done_rdata", ReadData, e_rd);
        chk("done_err", BusErr, 0);
        chk("done_valid", bus.BusValid, 0);
        chk("one_hs", hs_cnt - hs0, 1);
        model_rd = e_rd;
        if (hold) at_done = 1'b1;
        else begin
            MemRead = 0; MemWrite = 0;
            @(negedge clk);
            chk("idle_valid", bus.BusValid, 0);
            chk("idle_stall", Stall, 0);
            at_done = 1'b0;
        end
    endtask
    typedef struct {
        logic rd; logic wr; logic [2:0] f3; logic [31:0] a; logic [31:0] wd; logic [31:0] rdat;
        logic [31:0] e_wd; logic [3:0] e_strb; logic e_mis; logic [31:0] e_rd;
    } vec_t;
    vec_t tbl[10];
    initial begin
        logic rd, wr, e_mis;
        logic [2:0] f3;
        logic [31:0] a, wd, rdat, e_wd, e_rd;
        logic [3:0] e_strb;
        tbl[0] = '{1'b1, 1'b0, 3'd2, 32'h0000_1004, 32'h0, 32'hCAFE_F00D, 32'h0, 4'b0000, 1'b0, 32'hCAFE_F00D};
        tbl[1] = '{1'b0, 1'b1, 3'd0, 32'h0000_2003, 32'h1234_56A5, 32'h0, 32'hA5A5_A5A5, 4'b1000, 1'b0, 32'hCAFE_F00D};
        tbl[2] = '{1'b0, 1'b1, 3'd1, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 32'hBEEF_BEEF, 4'b1100, 1'b0, 32'hCAFE_F00D};
        tbl[3] = '{1'b1, 1'b0, 3'd2, 32'h0000_1002, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b1, 32'hCAFE_F00D};
        tbl[4] = '{1'b1, 1'b0, 3'd1, 32'h0000_1001, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b1, 32'hCAFE_F00D};
        tbl[5] = '{1'b1, 1'b0, 3'd4, 32'h0000_3001, 32'h0, 32'h1122_3344, 32'h0, 4'b0000, 1'b0, 32'h1122_3344};
        tbl[6] = '{1'b0, 1'b1, 3'd2, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h1122_3344};
        tbl[7] = '{1'b1, 1'b0, 3'd7, 32'h0000_5002, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b1, 32'h1122_3344};
        tbl[8] = '{1'b0, 1'b1, 3'd1, 32'h0000_0010, 32'h0000_ABCD, 32'h0, 32'hABCD_ABCD, 4'b0011, 1'b0, 32'h1122_3344};
        tbl[9] = '{1'b0, 1'b1, 3'd0, 32'h0000_0011, 32'h0000_007F, 32'h0, 32'h7F7F_7F7F, 4'b0010, 1'b0, 32'h1122_3344};
        reset = 1'b1;
        MemRead = 0; MemWrite = 0; Funct3 = 0; IEUAdr = 0; WriteData = 0;
        bus.BusReady = 0; bus.BusRValid = 0; bus.BusRData = 0;
        t_rd = 0; t_wr = 0; t_f3 = 3'd2; t_adr = 32'h100; t_wd = 0;
        bus8.BusReady = 0; bus8.BusRValid = 0; bus8.BusRData = 0;
        repeat (2) @(negedge clk);
        chk("rst_rdata", ReadData, 0);
        chk("rst_valid", bus.BusValid, 0);
        chk("rst_write", bus.BusWrite, 0);
        chk("rst_strb", bus.BusWStrb, 0);
        chk("rst_adr", bus.BusAdr, 0);
        chk("rst_wdata", bus.BusWData, 0);
        chk("rst_err", BusErr, 0);
        chk("rst_stall", Stall, 0);
        reset = 1'b0;
        @(negedge clk);
        foreach (tbl[k])
            access(tbl[k].rd, tbl[k].wr, tbl[k].f3, tbl[k].a, tbl[k].wd, tbl[k].rdat,
                   tbl[k].e_wd, tbl[k].e_strb, tbl[k].e_mis, tbl[k].e_rd, 0, 1, 1'b0);
        access(1, 0, 3'd2, 32'h0000_1008, 0, 32'h0BAD_C0DE, 0, 4'b0000, 0, 32'h0BAD_C0DE, 5, 3, 1'b0);
        access(1, 0, 3'd2, 32'h0000_0020, 0, 32'h1357_9BDF, 0, 4'b0000, 0, 32'h1357_9BDF, 0, 0, 1'b1);
        access(0, 1, 3'd2, 32'h0000_0024, 32'h0246_8ACE, 0, 32'h0246_8ACE, 4'b1111, 0, 32'h1357_9BDF, 1, 0, 1'b0);
        for (int n = 0; n < 40; n++) begin
            rd = 1'($urandom_range(0, 1));
            wr = !rd;
            f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            wd = $urandom;
            rdat = $urandom;
            model(rd, wr, f3, a, wd, rdat, e_wd, e_strb, e_mis, e_rd);
            access(rd, wr, f3, a, wd, rdat, e_wd, e_strb, e_mis, e_rd,
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        if (at_done) begin
            MemRead = 0; MemWrite = 0;
            @(negedge clk);
            at_done = 1'b0;
        end
        t_rd = 1'b1;
        @(negedge clk);
        bus8.BusReady = 1; bus8.BusRValid = 1; bus8.BusRData = 32'h1234_5678;
        @(negedge clk);
        bus8.BusReady = 0; bus8.BusRValid = 0;
        chk("t_fast_rdata", t_rdata, 32'h1234_5678);
        chk("t_fast_stall", t_stall, 0);
        t_rd = 1'b0;
        @(negedge clk);
        t_rd = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk("t_err", t_err, k == 9);
            chk("t_valid", bus8.BusValid, k < 9);
            chk("t_stall", t_stall, k < 9);
        end
        chk("t_rdata0", t_rdata, 0);
        t_rd = 1'b0;
        @(negedge clk);
        chk("t_err_pulse", t_err, 0);
        bus8.BusRValid = 1; bus8.BusRData = 32'hFFFF_FFFF;
        @(negedge clk);
        bus8.BusRValid = 0;
        chk("t_stray", t_rdata, 0);
        access(1, 0, 3'd2, 32'h0000_0700, 0, 32'h55AA_55AA, 0, 4'b0000, 0, 32'h55AA_55AA, 0, 1, 1'b0);
        MemRead = 1; Funct3 = 3'd2; IEUAdr = 32'h900;
        @(negedge clk);
        bus.BusReady = 1;
        @(negedge clk);
        bus.BusReady = 0;
        chk("resp_pre", bus.BusValid, 0);
        #2 reset = 1'b1; MemRead = 0;
        #1;
        chk("rr_rdata", ReadData, 0);
        chk("rr_adr", bus.BusAdr, 0);
        chk("rr_stall", Stall, 0);
        @(negedge clk);
        reset = 1'b0;
        bus.BusRValid = 1; bus.BusRData = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.BusRValid = 0;
        chk("rr_stray", ReadData, 0);
        MemRead = 1; IEUAdr = 32'hA00;
        @(negedge clk);
        chk("rq_valid", bus.BusValid, 1);
        #2 reset = 1'b1; MemRead = 0;
        #1;
        chk("rq_drop", bus.BusValid, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rq_idle", bus.BusValid, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
